// File: rtl/ax65_ram_req_ctrl.sv
// rtl/ax65_ram_req_ctrl.sv - valid/ready request stream to single-port byte-write SRAM pins, 2-entry read response buffer
// Optional post-reset zero-fill sweep is enabled by defining AX65_RAM_REQ_CTRL_INIT_EN.
module ax65_ram_req_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_BYTE    = 4,
  parameter int BIT_PER_BYTE = 8,
  localparam int NUM_WORDS   = 2**ADDR_WIDTH,
  localparam int DATA_WIDTH  = DATA_BYTE*BIT_PER_BYTE
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  input  logic [DATA_BYTE-1:0]  i_req_be,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_ram_cs,
  output logic [DATA_BYTE-1:0]  o_ram_bwe,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_din,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic                  o_init_busy
);

  logic                  rd_inflight_q, rd_inflight_d;
  logic [1:0]            wptr_q, wptr_d;
  logic [1:0]            rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [1:0]            count;
  logic [2:0]            occ_after_pop;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  acc;
  logic                  init_busy;

`ifdef AX65_RAM_REQ_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter wraps naturally to 0 on the last swept address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + ADDR_WIDTH'(1);
      if (cnt_q == ADDR_WIDTH'(NUM_WORDS-1)) state_d = ST_RUN;
    end
  end

  assign init_busy = (state_q == ST_INIT);
`else
  assign init_busy = 1'b0;
`endif

  assign o_init_busy = init_busy;

  // Occupancy counts the read already in the RAM pipe so the buffer can never overflow.
  assign count         = wptr_q - rptr_q;
  assign full          = (wptr_q[1] != rptr_q[1]) && (wptr_q[0] == rptr_q[0]);
  assign o_rsp_valid   = (wptr_q != rptr_q);
  assign o_rsp_rdata   = buf_q[rptr_q[0]];
  assign pop           = o_rsp_valid & i_rsp_ready;
  assign push          = rd_inflight_q;
  assign occ_after_pop = {1'b0, count} + {2'b00, rd_inflight_q} - {2'b00, pop};

  assign o_req_ready   = !i_rst && !init_busy && (i_req_we || (occ_after_pop < 3'd2));
  assign acc           = i_req_valid & o_req_ready;
  assign rd_inflight_d = acc & ~i_req_we;

  always_comb begin
    o_ram_cs   = acc;
    o_ram_bwe  = (acc && i_req_we) ? i_req_be : '0;
    o_ram_addr = i_req_addr;
    o_ram_din  = i_req_wdata;
`ifdef AX65_RAM_REQ_CTRL_INIT_EN
    if (init_busy && !i_rst) begin
      o_ram_cs   = 1'b1;
      o_ram_bwe  = '1;
      o_ram_addr = cnt_q;
      o_ram_din  = '0;
    end
`endif
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    buf_d  = buf_q;
    if (push) begin
      buf_d[wptr_q[0]] = i_ram_dout;
      wptr_d           = wptr_q + 2'd1;
    end
    if (pop) rptr_d = rptr_q + 2'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_inflight_q <= 1'b0;
      wptr_q        <= '0;
      rptr_q        <= '0;
    end else begin
      rd_inflight_q <= rd_inflight_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
    end
    buf_q <= buf_d;
  end

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst) !(push && full));

endmodule

// File: tb/tb_ax65_ram_req_ctrl.sv
// tb/tb_ax65_ram_req_ctrl.sv - directed self-checking bench for ax65_ram_req_ctrl with a behavioural byte-write RAM
module tb_ax65_ram_req_ctrl;
  localparam int AW = 5;
  localparam int DB = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DB-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          ram_cs;
  logic [DB-1:0] ram_bwe;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          init_busy;
  logic          preload_req = 1'b0;
  logic [DW-1:0] ram [32];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ax65_ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_BYTE(DB), .BIT_PER_BYTE(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_ram_cs(ram_cs), .o_ram_bwe(ram_bwe), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_init_busy(init_busy)
  );

  // Word i preloads to (i+1) replicated in every byte.
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 32; i++) ram[i] <= 32'h01010101 * (i + 1);
    end else if (ram_cs) begin
      ram_dout <= ram[ram_addr];
      for (int b = 0; b < DB; b++)
        if (ram_bwe[b]) ram[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
    end
  end

  task preload;
    @(negedge clk); preload_req = 1'b1;
    @(negedge clk); preload_req = 1'b0;
  endtask

  task do_reset;
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
`ifdef AX65_RAM_REQ_CTRL_INIT_EN
    begin
      int n;
      n = 0;
      while (init_busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
      total++;
      if (init_busy !== 1'b0) begin bad++; $display("FAIL reset_sweep_timeout busy=%b want 0", init_busy); end
    end
`endif
  endtask

  task test_reset;
    logic exp_busy;
`ifdef AX65_RAM_REQ_CTRL_INIT_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    @(negedge clk); rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 5'd9; req_wdata = 32'h12345678;
    #1;
    total++; if (ram_cs !== 1'b0) begin bad++; $display("FAIL reset_cs got=%b want 0", ram_cs); end
    total++; if (ram_bwe !== 4'h0) begin bad++; $display("FAIL reset_bwe got=%h want 0", ram_bwe); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want 0", rsp_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want 0", req_ready); end
    @(negedge clk); rst = 1'b0; req_valid = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_rsp_valid got=%b want 0", rsp_valid); end
    total++; if (init_busy !== exp_busy) begin bad++; $display("FAIL post_reset_busy got=%b want %b", init_busy, exp_busy); end
    total++; if (req_ready !== ~exp_busy) begin bad++; $display("FAIL post_reset_ready got=%b want %b", req_ready, ~exp_busy); end
    do_reset();
  endtask

`ifdef AX65_RAM_REQ_CTRL_INIT_EN
  task test_init;
    @(negedge clk); rst = 1'b1; req_valid = 1'b0;
    @(negedge clk); rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++;
      if (init_busy !== 1'b1 || ram_addr !== AW'(k) || ram_cs !== 1'b1)
        begin bad++; $display("FAIL init_first k=%0d busy=%b addr=%0d cs=%b", k, init_busy, ram_addr, ram_cs); end
    end
    rst = 1'b1;
    #1;
    total++; if (ram_cs !== 1'b0) begin bad++; $display("FAIL init_rst_cs got=%b want 0", ram_cs); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++;
      if (init_busy !== 1'b1 || ram_addr !== AW'(k) || ram_cs !== 1'b1 || ram_bwe !== 4'hF ||
          ram_din !== 32'h0 || req_ready !== 1'b0)
        begin bad++; $display("FAIL init_sweep k=%0d busy=%b addr=%0d cs=%b bwe=%h din=%h ready=%b",
                              k, init_busy, ram_addr, ram_cs, ram_bwe, ram_din, req_ready); end
    end
    @(negedge clk); req_addr = 5'd31; rsp_ready = 1'b1; #1;
    total++; if (init_busy !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL init_done busy=%b ready=%b want 0 1", init_busy, req_ready); end
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL init_read31 valid=%b data=%h want 1 0", rsp_valid, rsp_rdata); end
    @(negedge clk);
  endtask
`endif

  task test_back_to_back;
    logic [DW-1:0] exp [4];
    exp[0] = 32'h01010101; exp[1] = 32'h02020202; exp[2] = 32'h03030303; exp[3] = 32'h04040404;
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req_valid = (k < 4); req_we = 1'b0; req_addr = AW'(k);
      #1;
      if (k < 4) begin
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%b want 1", k, req_ready); end
        total++; if (ram_cs !== 1'b1 || ram_bwe !== 4'h0 || ram_addr !== AW'(k))
          begin bad++; $display("FAIL b2b_pins k=%0d cs=%b bwe=%h addr=%0d", k, ram_cs, ram_bwe, ram_addr); end
      end
      total++;
      if (k >= 2 && k < 6) begin
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp[k-2])
          begin bad++; $display("FAIL b2b_rsp k=%0d valid=%b data=%h want %h", k, rsp_valid, rsp_rdata, exp[k-2]); end
      end else if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL b2b_idle k=%0d valid=%b want 0", k, rsp_valid);
      end
    end
  endtask

  task test_backpressure;
    rsp_ready = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b want 1", req_ready); end
    @(negedge clk); req_addr = 5'd1; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%b want 1", req_ready); end
    @(negedge clk); req_addr = 5'd2; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full_read got=%b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h01010101) begin bad++; $display("FAIL bp_head valid=%b data=%h want 01010101", rsp_valid, rsp_rdata); end
    req_we = 1'b1; req_be = 4'hF; req_addr = 5'd20; req_wdata = 32'hCAFEF00D; #1;
    total++; if (req_ready !== 1'b1 || ram_cs !== 1'b1 || ram_bwe !== 4'hF)
      begin bad++; $display("FAIL bp_write ready=%b cs=%b bwe=%h want 1 1 f", req_ready, ram_cs, ram_bwe); end
    @(negedge clk); req_we = 1'b0; req_be = 4'h0; req_addr = 5'd2; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b want 0", req_ready); end
    total++; if (rsp_rdata !== 32'h01010101) begin bad++; $display("FAIL bp_hold data=%h want 01010101", rsp_rdata); end
    @(negedge clk); rsp_ready = 1'b1; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b want 1", req_ready); end
    total++; if (rsp_rdata !== 32'h01010101) begin bad++; $display("FAIL bp_drain0 data=%h want 01010101", rsp_rdata); end
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h02020202) begin bad++; $display("FAIL bp_drain1 valid=%b data=%h want 02020202", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h03030303) begin bad++; $display("FAIL bp_drain2 valid=%b data=%h want 03030303", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_empty valid=%b want 0", rsp_valid); end
  endtask

  task test_write_be;
    rsp_ready = 1'b1;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3; req_wdata = 32'hA5A5A5A5; req_be = 4'b0101; #1;
    total++; if (ram_cs !== 1'b1 || ram_bwe !== 4'b0101 || ram_addr !== 5'd3 || ram_din !== 32'hA5A5A5A5)
      begin bad++; $display("FAIL wbe_pins cs=%b bwe=%b addr=%0d din=%h", ram_cs, ram_bwe, ram_addr, ram_din); end
    @(negedge clk); req_we = 1'b0; req_be = 4'h0; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wbe_read_ready got=%b want 1", req_ready); end
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wbe_early valid=%b want 0", rsp_valid); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h04A504A5) begin bad++; $display("FAIL wbe_rsp valid=%b data=%h want 04a504a5", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wbe_after valid=%b want 0", rsp_valid); end
  endtask

  task test_be_zero;
    rsp_ready = 1'b1;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 32'h11111111; req_be = 4'hF;
    @(negedge clk); req_wdata = 32'hDEADBEEF; req_be = 4'h0; #1;
    total++; if (ram_cs !== 1'b1 || ram_bwe !== 4'h0) begin bad++; $display("FAIL be0_pins cs=%b bwe=%h want 1 0", ram_cs, ram_bwe); end
    @(negedge clk); req_we = 1'b0; req_addr = 5'd7; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL be0_norsp_a valid=%b want 0", rsp_valid); end
    @(negedge clk); req_addr = 5'd20; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL be0_norsp_b valid=%b want 0", rsp_valid); end
    @(negedge clk); req_valid = 1'b0; #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11111111) begin bad++; $display("FAIL be0_read7 valid=%b data=%h want 11111111", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL be0_read20 valid=%b data=%h want cafef00d", rsp_valid, rsp_rdata); end
    @(negedge clk); #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL be0_empty valid=%b want 0", rsp_valid); end
  endtask

  task test_reset_mid;
    rsp_ready = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd1;
    @(negedge clk); req_addr = 5'd2;
    @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre valid=%b want 1", rsp_valid); end
    total++; if (ram_cs !== 1'b0) begin bad++; $display("FAIL rmid_cs got=%b want 0", ram_cs); end
    @(negedge clk); rst = 1'b0; rsp_ready = 1'b1; #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_after valid=%b want 0", rsp_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale k=%0d valid=%b want 0", k, rsp_valid); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    preload();
    test_reset();
`ifdef AX65_RAM_REQ_CTRL_INIT_EN
    test_init();
    preload();
`endif
    test_back_to_back();
    test_backpressure();
    test_write_be();
    test_be_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
